// File: rtl/decod_scan_pkg.sv
// Shared definitions for the decod_scan registered one-hot decoder/scanner.
// Holds the FSM state encoding and a constant-foldable ceil(log2) helper.
package decod_scan_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StDirect = 2'd1,
    StScan   = 2'd2
  } state_e;

  // Returns ceil(log2(value)); 0 for value <= 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned span;
    result = 0;
    span   = 1;
    while (span < value) begin
      span   = span << 1;
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/onehot_dec.sv
// Combinational SEL_W -> 2**SEL_W one-hot decoder with optional one-cold output.
// When en is low every output bit is driven to its inactive level.
module onehot_dec #(
  parameter int unsigned SEL_W      = 3,
  parameter bit          ACTIVE_LOW = 1'b0,
  localparam int unsigned OUT_W     = 1 << SEL_W
) (
  input  logic [SEL_W-1:0] sel,
  input  logic             en,
  output logic [OUT_W-1:0] y
);

  always_comb begin
    y = '0;
    if (en) begin
      y[sel] = 1'b1;
    end
    if (ACTIVE_LOW) begin
      y = ~y;
    end
  end

endmodule

// File: rtl/decod_scan.sv
// Registered one-hot decoder with a direct mode and an auto-advancing scan mode.
// y is decoded from the next idx so that y and idx always update on the same edge.
module decod_scan
  import decod_scan_pkg::*;
#(
  parameter int unsigned  SEL_W      = 3,
  parameter int unsigned  DWELL      = 4,
  parameter bit           ACTIVE_LOW = 1'b0,
  localparam int unsigned OUT_W      = 1 << SEL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic [SEL_W-1:0] sel,
  input  logic             load,
  output logic [OUT_W-1:0] y,
  output logic [SEL_W-1:0] idx,
  output logic             valid,
  output logic             wrap
);

  localparam int unsigned      CNT_W    = (clog2(DWELL) < 1) ? 1 : clog2(DWELL);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DWELL - 1);
  localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(OUT_W - 1);
  localparam logic [OUT_W-1:0] Y_IDLE   = {OUT_W{ACTIVE_LOW}};

  state_e           state_q, state_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OUT_W-1:0] y_q, y_d;
  logic             valid_q, valid_d;
  logic             wrap_q, wrap_d;

  always_comb begin
    state_d = StIdle;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    wrap_d  = 1'b0;
    if (!en) begin
      state_d = StIdle;
    end else if (!mode) begin
      state_d = StDirect;
      idx_d   = sel;
      cnt_d   = '0;
      valid_d = 1'b1;
    end else begin
      state_d = StScan;
      valid_d = 1'b1;
      if (load) begin
        idx_d = sel;
        cnt_d = '0;
      end else if (state_q != StScan) begin
        // Entering scan: hold the retained index for a full dwell.
        cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
        idx_d  = idx_q + 1'b1;
        cnt_d  = '0;
        wrap_d = (idx_q == IDX_LAST);
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  onehot_dec #(
    .SEL_W      (SEL_W),
    .ACTIVE_LOW (ACTIVE_LOW)
  ) u_dec (
    .sel (idx_d),
    .en  (valid_d),
    .y   (y_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      cnt_q   <= '0;
      y_q     <= Y_IDLE;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
    end
  end

  assign y     = y_q;
  assign idx   = idx_q;
  assign valid = valid_q;
  assign wrap  = wrap_q;

  // Exactly one active bit while valid, none otherwise.
  assert property (@(posedge clk) disable iff (rst)
    $countones(y_q ^ Y_IDLE) == (valid_q ? 1 : 0));

endmodule

// File: doc/decod_scan.md
Name: decod_scan

Overview:
- Parametrised, registered N-to-2^N one-hot decoder.
- Successor to the fixed 3-to-8 combinational decoder.
- Two modes:
  - Direct: a registered decode of `sel`.
  - Scan: auto-advancing one-hot walk with a programmable dwell time per position.
- Used for digit and row multiplexing on display and keypad front-ends, and as a one-hot chip-select generator.

Parameters:
- SEL_W, 3, select width. Legal range 1..6.
- OUT_W, 2**SEL_W, output width. Localparam, not overridable.
- DWELL, 4, clock cycles each position is held in scan mode. Legal range 1..65535.
- ACTIVE_LOW, 0, when 1 the asserted output bit is 0 and inactive bits are 1.

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous reset, active-high
- en  in  1  block enable
- mode  in  1  0 = direct decode, 1 = scan
- sel  in  SEL_W  direct-mode index; scan-mode start index on load
- load  in  1  scan mode only: restart scan at sel
- y  out  OUT_W  registered one-hot (or one-cold) output
- idx  out  SEL_W  index currently driven on y
- valid  out  1  y holds a live decode
- wrap  out  1  one-cycle pulse when scan advances from OUT_W-1 to 0

Behaviour:
- Reset (rst=1 at clock edge), which has priority over everything:
  - y = all inactive (0s, or 1s if ACTIVE_LOW).
  - idx = 0, valid = 0, wrap = 0.
  - Dwell counter = 0, state = IDLE.
- Clocked FSM, states IDLE, DIRECT, SCAN, re-evaluated every edge:
  - en=0 → IDLE.
  - en=1 and mode=0 → DIRECT.
  - en=1 and mode=1 → SCAN.
- IDLE:
  - y inactive, valid = 0, wrap = 0.
  - idx and the dwell counter hold their values.
- DIRECT:
  - Latency 1: the edge sampling sel sets idx = sel and y = onehot(sel); valid = 1.
  - Dwell counter held at 0; wrap = 0.
  - load is ignored.
- SCAN:
  - valid = 1; y = onehot(idx) registered together with idx, so y and idx are always consistent.
  - Dwell counter counts 0..DWELL-1.
  - At terminal count (DWELL-1): idx = idx+1 mod OUT_W and the counter clears.
  - wrap = 1 for exactly the cycle in which idx becomes 0 through advance; otherwise 0.
  - DWELL=1: idx advances every cycle.
- load in SCAN:
  - idx = sel, counter cleared, wrap = 0.
  - Has priority over a same-cycle advance.
  - load with sel equal to the current idx still clears the counter.
- Entry into SCAN from DIRECT or IDLE:
  - Starts at the retained idx with the counter cleared.
  - First advance occurs DWELL cycles after entry.
- SCAN → DIRECT: takes sel on the same edge; wrap forced 0.
- Simultaneous events:
  - rst beats everything.
  - en=0 beats load and mode.
- Width and arithmetic:
  - idx wraps naturally in SEL_W bits.
  - Dwell counter width is clog2(DWELL), minimum 1 bit.
  - No out-of-range index is possible.
- Invariant: exactly one active bit in y when valid=1; zero active bits when valid=0.

Decomposition:
- Shared package:
  - State encoding constants (IDLE=2'd0, DIRECT=2'd1, SCAN=2'd2).
  - clog2 function.
- One natural sub-module, `onehot_dec`: purely combinational SEL_W → OUT_W decode with ACTIVE_LOW inversion. The top instantiates it ahead of the y register.

Test Plan:
- Reset, then release with en=0 → y=8'h00, idx=0, valid=0 for 10 cycles.
- Direct mode, SEL_W=3, en=1, mode=0, sel=3'b010 → next cycle y=8'b0000_0100, idx=2, valid=1. Sweep sel 0..7 → y matches 1<<sel at latency 1.
- Scan mode, DWELL=4, from idx=0:
  - idx steps 0→1→…→7→0, each held exactly 4 cycles.
  - wrap high for exactly 1 cycle as idx becomes 0.
  - Full period 32 cycles.
- Scan, load=1 with sel=5 on the same cycle as a terminal count → idx=5, counter cleared, wrap=0, next advance to 6 after 4 cycles.
- ACTIVE_LOW=1, SEL_W=2, DWELL=1 → y cycles 4'b1110, 1101, 1011, 0111 on consecutive cycles. After reset, y=4'b1111.
- Reset mid-scan (idx=6, counter=2), rst=1 for one cycle → y inactive, idx=0, valid=0. With en=1, mode=1 held, the scan restarts at idx=0 with a full 4-cycle dwell.
